// File: rtl/manhattan_pipe.sv
// manhattan_pipe: two-stage L1 distance and signed split-axis delta for the kd-tree search engine.
// Define MANHATTAN_PRUNE_EN to add the best_dist input and the registered prune output.
module manhattan_pipe #(
   parameter int DIM        = 3,
   parameter int DATA_RANGE = 255,
   parameter int COORD_W    = $clog2(DATA_RANGE + 1),
   parameter int DIST_W     = $clog2(DATA_RANGE * DIM + 1),
   parameter int AXIS_W     = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AXIS_W-1:0]      axis,
   input  logic [DIM*COORD_W-1:0] a,
   input  logic [DIM*COORD_W-1:0] b,
   input  logic [DIM*COORD_W-1:0] c,
`ifdef MANHATTAN_PRUNE_EN
   input  logic [DIST_W-1:0]      best_dist,
   output logic                   prune,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DIST_W-1:0]      dist_out,
   output logic [COORD_W:0]       single_dist_out,
   output logic                   axis_err
);

   logic                 w_adv;
   logic [COORD_W:0]     w_diff [DIM];
   logic [COORD_W-1:0]   w_abs [DIM];
   logic [COORD_W-1:0]   w_c_sel;
   logic [COORD_W-1:0]   w_b_sel;
   logic                 w_axis_err;
   logic [COORD_W:0]     w_single;
   logic [DIST_W-1:0]    w_sum;

   logic                 r_s1_valid;
   logic [COORD_W-1:0]   r_s1_abs [DIM];
   logic [COORD_W:0]     r_s1_single;
   logic                 r_s1_err;

   // Whole pipe moves together; a held output freezes both stages.
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   always_comb begin
      w_c_sel    = '0;
      w_b_sel    = '0;
      w_axis_err = (int'(axis) >= DIM);
      for (int k = 0; k < DIM; k++) begin
         // One extra bit keeps the difference exact for any pair of coordinates.
         w_diff[k] = {1'b0, a[k*COORD_W +: COORD_W]} - {1'b0, b[k*COORD_W +: COORD_W]};
         w_abs[k]  = w_diff[k][COORD_W] ? (~w_diff[k][COORD_W-1:0] + 1'b1)
                                        : w_diff[k][COORD_W-1:0];
         if (int'(axis) == k) begin
            w_c_sel = c[k*COORD_W +: COORD_W];
            w_b_sel = b[k*COORD_W +: COORD_W];
         end
      end
      w_single = w_axis_err ? '0 : ({1'b0, w_c_sel} - {1'b0, w_b_sel});
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < DIM; k++) begin
         w_sum = w_sum + DIST_W'(r_s1_abs[k]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_single <= '0;
         r_s1_err    <= 1'b0;
         for (int k = 0; k < DIM; k++) begin
            r_s1_abs[k] <= '0;
         end
      end else if (w_adv) begin
         r_s1_valid  <= in_valid && in_ready;
         r_s1_single <= w_single;
         r_s1_err    <= w_axis_err;
         for (int k = 0; k < DIM; k++) begin
            r_s1_abs[k] <= w_abs[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid       <= 1'b0;
         dist_out        <= '0;
         single_dist_out <= '0;
         axis_err        <= 1'b0;
      end else if (w_adv) begin
         out_valid       <= r_s1_valid;
         dist_out        <= w_sum;
         single_dist_out <= r_s1_single;
         axis_err        <= r_s1_err;
      end
   end

`ifdef MANHATTAN_PRUNE_EN
   logic [DIST_W-1:0]  r_s1_best;
   logic [COORD_W:0]   w_single_mag;
   logic               w_prune;

   assign w_single_mag = r_s1_single[COORD_W] ? -r_s1_single : r_s1_single;
   // An invalid axis never prunes, even against a zero best distance.
   assign w_prune      = !r_s1_err && (int'(w_single_mag) >= int'(r_s1_best));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_best <= '0;
         prune     <= 1'b0;
      end else if (w_adv) begin
         r_s1_best <= best_dist;
         prune     <= w_prune;
      end
   end
`endif

endmodule

// File: doc/manhattan_pipe.md
Name: manhattan_pipe

Overview:
- Pipelined, DIM-generic successor to the combinational Manhattan distance unit used by the kd-tree search engine.
- Per accepted request computes:
  - full L1 distance between current point a and parent point b;
  - signed split-axis distance c[axis] - b[axis], where c is the current best.
- Valid/ready on both sides, 2-cycle latency, one result per cycle.
- Fixes the old unit's 8-bit delta wrap on coordinate differences and its hard-coded 3-D slicing.

Parameters:
- DIM, 3, number of coordinate dimensions (>= 1).
- DATA_RANGE, 255, maximum unsigned coordinate value.
- COORD_W, $clog2(DATA_RANGE+1), derived: bits per coordinate.
- DIST_W, $clog2(DATA_RANGE*DIM+1), derived: full-distance width.
- AXIS_W, (DIM>1 ? $clog2(DIM) : 1), derived: axis index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- axis  in  AXIS_W  split axis for single-axis distance.
- a  in  DIM*COORD_W  current point; dimension k at [k*COORD_W +: COORD_W].
- b  in  DIM*COORD_W  parent point, same packing.
- c  in  DIM*COORD_W  best point, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- dist_out  out  DIST_W  sum over k of |a[k]-b[k]|.
- single_dist_out  out  COORD_W+1  signed two's-complement c[axis]-b[axis].
- axis_err  out  1  axis >= DIM for this result.

Behaviour:
- Reset (rst low, async): S1/S2 valid bits cleared; out_valid=0; dist_out, single_dist_out, axis_err = 0. Datapath regs cleared too.
- Advance signal: adv = !out_valid || out_ready. in_ready = adv (combinational).
- Stage S1, loaded when adv:
  - s1_valid <= in_valid && in_ready.
  - Per dimension k: d = {1'b0,a[k]} - {1'b0,b[k]} in COORD_W+1 bits; abs stored in COORD_W bits. No wrap for any a,b in 0..DATA_RANGE.
  - Single: {1'b0,c[axis]} - {1'b0,b[axis]}, COORD_W+1 signed.
  - axis >= DIM: single = 0, err flag = 1.
- Stage S2, loaded when adv:
  - out_valid <= s1_valid.
  - dist_out <= zero-extended sum of all DIM abs deltas, DIST_W bits, never overflows.
  - single_dist_out and axis_err forwarded.
- Latency: a request accepted at edge N is presented at edge N+2 if out_ready is held high.
- Throughput: 1 per cycle with out_ready high.
- Stall (out_valid && !out_ready):
  - whole pipe freezes; in_ready=0;
  - all outputs stable until the handshake completes.
- Bubbles: idle cycles propagate as invalid. Data regs may hold stale values when their valid bit is 0. Output data is don't-care while out_valid=0.
- Output handshake and a new input accept may occur in the same cycle; no loss, no duplication.
- Reset mid-operation: in-flight results are discarded; first post-reset accept follows normal latency.
- No en input; an unused block simply sees in_valid=0.

Optional Feature:
- Macro: MANHATTAN_PRUNE_EN.
- Defined:
  - Extra input best_dist [DIST_W-1:0], captured in S1 with the request.
  - Extra output prune [1], registered in S2 alongside the result.
  - prune = 1 when |single_dist_out| >= best_dist, meaning the far subtree is skipped.
  - prune = 0 when axis_err = 1.
  - Reset value of prune: 0.
- Not defined: ports absent; behaviour otherwise identical.

Test Plan (DIM=3, DATA_RANGE=255):
- Reset: hold rst low, drive in_valid=1 -> out_valid=0 and all outputs 0; release -> first accept yields out_valid two edges later.
- Wrap check:
  - a=(10,200,30), b=(250,5,30), c=(100,50,7), axis=1, out_ready=1 -> dist_out=435, single_dist_out=+45, axis_err=0.
  - Same a,b,c with axis=0 -> single_dist_out=-150 (9'h16A).
- Back-to-back: 8 consecutive requests (incl. a=b -> dist 0, a=(255,255,255), b=0 -> 765), out_ready=1 -> results in order, one per cycle, in_ready constantly 1.
- Backpressure: out_ready=0 for 4 cycles with 3 requests issued -> in_ready drops once 2 results are queued, outputs stable; release -> all 3 delivered in order, none duplicated.
- Axis error: axis=3 -> axis_err=1, single_dist_out=0, dist_out still correct.
- MANHATTAN_PRUNE_EN:
  - single -150, best_dist=150 -> prune=1.
  - best_dist=151 -> prune=0.
  - axis=3 -> prune=0.
